// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_pkg
// Purpose  : Shared types for the CDB writeback arbiter. Provides the source
//            encodings, the ROB id width and the broadcast payload struct.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

package cdb_arbiter_pkg;

  localparam int ROB_W = `ROB_WIDTH;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_W-1:0] rob_id;
    logic [31:0]      value;
  } cdb_payload_t;

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cdb_src_fifo
// Purpose  : Small per-source result FIFO feeding the CDB arbiter.
// Ports    : clk_in/rst_in   - clock, synchronous active-high reset
//            push_i/wdata_i  - write one {rob_id, value} entry at the tail
//            pop_i           - advance the head
//            flush_i         - discard all entries
//            hold_i          - freeze all state (overrides push/pop/flush)
//            head_o          - entry at the head
//            count_o         - occupancy; empty_o / full_o flags
// Revision : 1.0 - initial release
// ============================================================================
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int ROB_W = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic               hold_i,
  input  logic [ROB_W+31:0]  wdata_i,
  output logic [ROB_W+31:0]  head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ROB_W+31:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign do_push = push_i && !hold_i && !flush_i;
  assign do_pop  = pop_i  && !hold_i && !flush_i;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!hold_i) begin
      if (flush_i) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (do_push) tail_d = tail_q + PTR_W'(1);
        if (do_pop)  head_d = head_q + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (count_q <= FULL_CNT) else $error("cdb_src_fifo: count above DEPTH");
      assert (!(do_pop && count_q == '0)) else $error("cdb_src_fifo: pop while empty");
      assert (!(do_push && count_q == FULL_CNT)) else $error("cdb_src_fifo: push while full");
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Shares the common data bus between the ALU and the load/store
//            buffer. Each source fills its own FIFO; a round-robin scheduler
//            issues at most one result per cycle onto a registered broadcast.
// Ports    : clk_in, rst_in, rdy_in, clear         - control
//            alu_valid/rob_id/value, alu_ready     - ALU result input
//            lsb_valid/rob_id/value, lsb_ready     - LSB result input
//            cdb_valid/rob_id/value/src            - registered broadcast
//            alu_occ, lsb_occ                      - FIFO occupancies
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W = cdb_arbiter_pkg::ROB_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_value,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_value,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_value,
  output logic             cdb_src,
  output logic [CNT_W-1:0] alu_occ,
  output logic [CNT_W-1:0] lsb_occ
);

  cdb_payload_t alu_head, lsb_head, grant_head;
  logic         alu_empty, alu_full, lsb_empty, lsb_full;
  logic         alu_push, lsb_push, alu_pop, lsb_pop;
  logic         active;
  logic         grant_valid;
  cdb_src_e     grant_src;

  cdb_src_e         last_grant_q, last_grant_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]      cdb_value_q, cdb_value_d;
  cdb_src_e         cdb_src_q, cdb_src_d;

  assign active = rdy_in && !clear;

  // Ready ignores a same-cycle pop: a full FIFO never accepts.
  assign alu_ready = active && !alu_full;
  assign lsb_ready = active && !lsb_full;
  assign alu_push  = alu_valid && alu_ready;
  assign lsb_push  = lsb_valid && lsb_ready;

  always_comb begin
    grant_valid = 1'b1;
    grant_src   = SRC_ALU;
    if (!alu_empty && !lsb_empty) begin
      grant_src = (last_grant_q == SRC_ALU) ? SRC_LSB : SRC_ALU;
    end else if (!lsb_empty) begin
      grant_src = SRC_LSB;
    end else if (alu_empty) begin
      grant_valid = 1'b0;
    end
  end

  assign grant_head = (grant_src == SRC_LSB) ? lsb_head : alu_head;
  assign alu_pop    = active && grant_valid && (grant_src == SRC_ALU);
  assign lsb_pop    = active && grant_valid && (grant_src == SRC_LSB);

  cdb_src_fifo #(.DEPTH(DEPTH), .ROB_W(ROB_W), .CNT_W(CNT_W)) u_alu_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (alu_push),
    .pop_i   (alu_pop),
    .flush_i (clear),
    .hold_i  (!rdy_in),
    .wdata_i ({alu_rob_id, alu_value}),
    .head_o  (alu_head),
    .count_o (alu_occ),
    .empty_o (alu_empty),
    .full_o  (alu_full)
  );

  cdb_src_fifo #(.DEPTH(DEPTH), .ROB_W(ROB_W), .CNT_W(CNT_W)) u_lsb_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (lsb_push),
    .pop_i   (lsb_pop),
    .flush_i (clear),
    .hold_i  (!rdy_in),
    .wdata_i ({lsb_rob_id, lsb_value}),
    .head_o  (lsb_head),
    .count_o (lsb_occ),
    .empty_o (lsb_empty),
    .full_o  (lsb_full)
  );

  // Idle cycles drop valid but keep the last id/value on the bus.
  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    if (rdy_in) begin
      if (clear) begin
        cdb_valid_d  = 1'b0;
        last_grant_d = SRC_LSB;
      end else if (grant_valid) begin
        cdb_valid_d  = 1'b1;
        cdb_rob_id_d = grant_head.rob_id;
        cdb_value_d  = grant_head.value;
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
      end else begin
        cdb_valid_d  = 1'b0;
      end
    end
  end

  // Reset leaves last_grant on the LSB so the ALU wins the first tie.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_src    = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter. Accepted results go into
//            per-source expectation queues and are matched as they appear on
//            the CDB; directed steps check occupancy, readiness and ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int ROB_W = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_in, rdy_in, clear;
  logic             alu_valid, lsb_valid;
  logic [ROB_W-1:0] alu_rob_id, lsb_rob_id;
  logic [31:0]      alu_value, lsb_value;
  logic             alu_ready, lsb_ready;
  logic             cdb_valid, cdb_src;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0]      cdb_value;
  logic [CNT_W-1:0] alu_occ, lsb_occ;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_W(ROB_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src),
    .alu_occ    (alu_occ),
    .lsb_occ    (lsb_occ)
  );

  typedef struct {
    logic [ROB_W-1:0] id;
    logic [31:0]      val;
  } item_t;

  item_t alu_pend[$], lsb_pend[$];   // offered, not yet accepted
  item_t exp_alu[$], exp_lsb[$];     // accepted, not yet broadcast
  logic  exp_src[$];                 // optional expected source sequence

  int   checks = 0;
  int   errors = 0;
  logic upd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input int id, input logic [31:0] v);
    item_t it;
    it.id  = ROB_W'(id);
    it.val = v;
    return it;
  endfunction

  // A broadcast is new only if the preceding edge was live (rdy_in=1, no reset).
  always @(posedge clk) upd <= rdy_in && !rst_in;

  always @(negedge clk) begin
    item_t e;
    if (upd && cdb_valid) begin
      if (exp_src.size() != 0) chk("cdb_src_order", 64'(cdb_src), 64'(exp_src.pop_front()));
      if (cdb_src == 1'b0) begin
        chk("alu_result_expected", 64'(exp_alu.size() != 0), 64'd1);
        if (exp_alu.size() != 0) begin
          e = exp_alu.pop_front();
          chk("alu_rob_id", 64'(cdb_rob_id), 64'(e.id));
          chk("alu_value", 64'(cdb_value), 64'(e.val));
        end
      end else begin
        chk("lsb_result_expected", 64'(exp_lsb.size() != 0), 64'd1);
        if (exp_lsb.size() != 0) begin
          e = exp_lsb.pop_front();
          chk("lsb_rob_id", 64'(cdb_rob_id), 64'(e.id));
          chk("lsb_value", 64'(cdb_value), 64'(e.val));
        end
      end
    end
  end

  // One clock: offer pending items, record what the edge accepts.
  task automatic tick();
    logic acc_a, acc_l;
    alu_valid = (alu_pend.size() != 0);
    lsb_valid = (lsb_pend.size() != 0);
    if (alu_valid) begin alu_rob_id = alu_pend[0].id; alu_value = alu_pend[0].val; end
    if (lsb_valid) begin lsb_rob_id = lsb_pend[0].id; lsb_value = lsb_pend[0].val; end
    #1;
    acc_a = alu_valid && alu_ready;
    acc_l = lsb_valid && lsb_ready;
    @(posedge clk);
    if (acc_a) exp_alu.push_back(alu_pend.pop_front());
    if (acc_l) exp_lsb.push_back(lsb_pend.pop_front());
    #1;
  endtask

  task automatic flush_model();
    alu_pend.delete(); lsb_pend.delete();
    exp_alu.delete();  exp_lsb.delete();
    exp_src.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((alu_pend.size() + lsb_pend.size() + exp_alu.size() + exp_lsb.size()) != 0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_alu_left"}, 64'(alu_pend.size() + exp_alu.size()), 64'd0);
    chk({tag, "_lsb_left"}, 64'(lsb_pend.size() + exp_lsb.size()), 64'd0);
    chk({tag, "_src_left"}, 64'(exp_src.size()), 64'd0);
  endtask

  initial begin
    int max_lsb;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    tick(); tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_alu_occ", 64'(alu_occ), 64'd0);
    chk("rst_lsb_occ", 64'(lsb_occ), 64'd0);

    // 1: single ALU result, two-edge latency, one-cycle valid
    chk("t1_alu_ready", 64'(alu_ready), 64'd1);
    alu_pend.push_back(mk(3, 32'h0000_00AA));
    tick();
    chk("t1_valid_early", 64'(cdb_valid), 64'd0);
    chk("t1_alu_occ", 64'(alu_occ), 64'd1);
    tick();
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_rob_id", 64'(cdb_rob_id), 64'd3);
    chk("t1_value", 64'(cdb_value), 64'hAA);
    chk("t1_src", 64'(cdb_src), 64'd0);
    tick();
    chk("t1_valid_drop", 64'(cdb_valid), 64'd0);

    // 2: both saturated from reset -> strict alternation, no gaps
    rst_in = 1'b1; tick(); rst_in = 1'b0; flush_model();
    for (int i = 1; i <= 3; i++) begin
      alu_pend.push_back(mk(i, 32'hA000_0000 | i));
      lsb_pend.push_back(mk(i + 8, 32'hB000_0000 | (i + 8)));
      exp_src.push_back(1'b0);
      exp_src.push_back(1'b1);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t2_no_gap", 64'(cdb_valid), (k >= 2 && k <= 7) ? 64'd1 : 64'd0);
    end
    drain("t2");

    // 3: LSB burst against a busy bus, LSB FIFO fills
    max_lsb = 0;
    for (int i = 4; i <= 7; i++) alu_pend.push_back(mk(i, 32'hA100_0000 | i));
    for (int i = 12; i <= 14; i++) lsb_pend.push_back(mk(i, 32'hB100_0000 | i));
    for (int k = 0; k < 6; k++) begin
      tick();
      if (int'(lsb_occ) > max_lsb) max_lsb = int'(lsb_occ);
      if (lsb_occ == 2'd2) chk("t3_lsb_ready_full", 64'(lsb_ready), 64'd0);
    end
    chk("t3_lsb_occ_max", 64'(max_lsb), 64'd2);
    drain("t3");

    // 4: clear flushes buffered results; clear also restores ALU tie priority
    clear = 1'b1; tick(); clear = 1'b0;
    alu_pend.push_back(mk(6, 32'hA200_0006)); alu_pend.push_back(mk(7, 32'hA200_0007));
    lsb_pend.push_back(mk(12, 32'hB200_000C)); lsb_pend.push_back(mk(13, 32'hB200_000D));
    tick(); tick();
    chk("t4_alu_occ_pre", 64'(alu_occ), 64'd1);
    chk("t4_lsb_occ_pre", 64'(lsb_occ), 64'd2);
    lsb_pend.push_back(mk(14, 32'hB200_000E));
    clear = 1'b1;
    #1;
    chk("t4_alu_ready_clear", 64'(alu_ready), 64'd0);
    chk("t4_lsb_ready_clear", 64'(lsb_ready), 64'd0);
    tick();
    clear = 1'b0;
    chk("t4_valid_after_clear", 64'(cdb_valid), 64'd0);
    chk("t4_alu_occ_clear", 64'(alu_occ), 64'd0);
    chk("t4_lsb_occ_clear", 64'(lsb_occ), 64'd0);
    flush_model();
    alu_pend.push_back(mk(5, 32'h0000_0055));
    tick(); tick();
    chk("t4_new_valid", 64'(cdb_valid), 64'd1);
    chk("t4_new_id", 64'(cdb_rob_id), 64'd5);
    chk("t4_new_src", 64'(cdb_src), 64'd0);
    tick();

    // 5: rdy_in low freezes everything, stream resumes in order
    alu_pend.push_back(mk(1, 32'hA300_0001)); alu_pend.push_back(mk(2, 32'hA300_0002));
    lsb_pend.push_back(mk(8, 32'hB300_0008)); lsb_pend.push_back(mk(9, 32'hB300_0009));
    tick(); tick();
    alu_pend.push_back(mk(3, 32'hA300_0003));
    lsb_pend.push_back(mk(10, 32'hB300_000A));
    rdy_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_hold_valid", 64'(cdb_valid), 64'd1);
      chk("t5_hold_id", 64'(cdb_rob_id), 64'd8);
      chk("t5_hold_src", 64'(cdb_src), 64'd1);
      chk("t5_hold_alu_occ", 64'(alu_occ), 64'd2);
      chk("t5_hold_lsb_occ", 64'(lsb_occ), 64'd1);
      chk("t5_hold_ready", 64'({alu_ready, lsb_ready}), 64'd0);
    end
    rdy_in = 1'b1;
    exp_src.push_back(1'b0); exp_src.push_back(1'b1); exp_src.push_back(1'b0);
    exp_src.push_back(1'b1); exp_src.push_back(1'b0);
    drain("t5");

    // 6: reset mid-stream, then first tie goes to the ALU
    alu_pend.push_back(mk(4, 32'hA400_0004)); alu_pend.push_back(mk(5, 32'hA400_0005));
    lsb_pend.push_back(mk(11, 32'hB400_000B)); lsb_pend.push_back(mk(12, 32'hB400_000C));
    tick(); tick();
    chk("t6_alu_occ_pre", 64'(alu_occ), 64'd2);
    chk("t6_lsb_occ_pre", 64'(lsb_occ), 64'd1);
    alu_pend.push_back(mk(6, 32'hA400_0006));
    lsb_pend.push_back(mk(13, 32'hB400_000D));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("t6_rst_valid", 64'(cdb_valid), 64'd0);
    chk("t6_rst_id", 64'(cdb_rob_id), 64'd0);
    chk("t6_rst_value", 64'(cdb_value), 64'd0);
    chk("t6_rst_src", 64'(cdb_src), 64'd0);
    chk("t6_rst_occ", 64'({alu_occ, lsb_occ}), 64'd0);
    flush_model();
    alu_pend.push_back(mk(7, 32'hA500_0007));
    lsb_pend.push_back(mk(14, 32'hB500_000E));
    exp_src.push_back(1'b0); exp_src.push_back(1'b1);
    tick(); tick();
    chk("t6_tie_src", 64'(cdb_src), 64'd0);
    chk("t6_tie_id", 64'(cdb_rob_id), 64'd7);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
